// File: rtl/pwm_ramp_controller.sv
// rtl/pwm_ramp_controller.sv - slew-limited duty sequencer for the heater/fan PWM generator
// Optional watchdog fault path enabled by defining PWM_RAMP_WATCHDOG_EN.
module pwm_ramp_controller #(
  parameter int STEP_DIV  = 50000,
  parameter int STEP_SIZE = 1,
  parameter int WDT_STEPS = 1000
) (
  input  logic       i_Clock50MHz,
  input  logic       i_Reset,
  input  logic       i_TargetValid,
  input  logic [7:0] i_TargetDuty,
  output logic       o_TargetReady,
  input  logic       i_Enable,
  input  logic       i_ClearFault,
  output logic [7:0] o_DutyCycle,
  output logic       o_AtTarget,
  output logic       o_Busy,
  output logic       o_Fault,
  output logic [2:0] o_State
);

  localparam int             CW      = $clog2(STEP_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STEP_DIV - 1);
  localparam logic [8:0]     STEP9   = 9'(STEP_SIZE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RAMP_DOWN = 3'd2,
    HOLD      = 3'd3,
    FAULT     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic [7:0]    tgt_q, tgt_d;
  logic [7:0]    eff_tgt;
  logic [8:0]    up_sum, dn_diff;
  logic          tick, accept, in_fault;

`ifdef PWM_RAMP_WATCHDOG_EN
  localparam int          WW      = $clog2(WDT_STEPS + 1);
  localparam logic [WW-1:0] WDT_MAX = WW'(WDT_STEPS);
  logic [WW-1:0] wdt_q, wdt_d;
  logic          go_fault;

  assign in_fault = (state_q == FAULT);
  assign go_fault = !in_fault && !accept && (wdt_q == WDT_MAX) && (eff_tgt != 8'd0);
`else
  logic clear_fault_unused;

  assign in_fault           = 1'b0;
  assign clear_fault_unused = i_ClearFault;
`endif

  assign tick          = (cnt_q == CNT_MAX);
  assign eff_tgt       = i_Enable ? tgt_q : 8'd0;
  assign o_TargetReady = !in_fault;
  assign accept        = i_TargetValid && o_TargetReady;
  // 9-bit intermediates so a step past 255 or below 0 is seen and clamped to the target
  assign up_sum        = {1'b0, duty_q} + STEP9;
  assign dn_diff       = {1'b0, duty_q} - STEP9;

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    tgt_d   = accept ? i_TargetDuty : tgt_q;
    duty_d  = duty_q;
    state_d = state_q;

    if (tick) begin
      if (eff_tgt > duty_q) begin
        duty_d = (up_sum > {1'b0, eff_tgt}) ? eff_tgt : up_sum[7:0];
      end else if (eff_tgt < duty_q) begin
        duty_d = (dn_diff[8] || (dn_diff[7:0] < eff_tgt)) ? eff_tgt : dn_diff[7:0];
      end
    end

    case (state_q)
      FAULT: state_d = FAULT;
      default: begin
        if (eff_tgt > duty_q)      state_d = RAMP_UP;
        else if (eff_tgt < duty_q) state_d = RAMP_DOWN;
        else if (eff_tgt == 8'd0)  state_d = IDLE;
        else                       state_d = HOLD;
      end
    endcase

`ifdef PWM_RAMP_WATCHDOG_EN
    wdt_d = wdt_q;
    if (accept || eff_tgt == 8'd0) wdt_d = '0;
    else if (tick)                 wdt_d = wdt_q + WW'(1);

    // Fault drops the load at once rather than ramping it down
    if (go_fault) begin
      state_d = FAULT;
      duty_d  = 8'd0;
      tgt_d   = 8'd0;
      wdt_d   = '0;
      cnt_d   = '0;
    end else if (in_fault) begin
      state_d = i_ClearFault ? IDLE : FAULT;
      duty_d  = 8'd0;
      tgt_d   = 8'd0;
      wdt_d   = '0;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge i_Clock50MHz or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= 8'd0;
      tgt_q   <= 8'd0;
`ifdef PWM_RAMP_WATCHDOG_EN
      wdt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
`ifdef PWM_RAMP_WATCHDOG_EN
      wdt_q   <= wdt_d;
`endif
    end
  end

  assign o_DutyCycle = duty_q;
  assign o_AtTarget  = (duty_q == eff_tgt) && !in_fault;
  assign o_Busy      = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  assign o_Fault     = in_fault;
  assign o_State     = state_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// tb/tb_pwm_ramp_controller.sv - directed scoreboard bench for pwm_ramp_controller
module tb_pwm_ramp_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tvalid = 1'b0;
  logic [7:0] tduty = 8'd0;
  logic       tready;
  logic       enable = 1'b1;
  logic       clear_fault = 1'b0;
  logic [7:0] duty;
  logic       at_target, busy, fault;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int n;
  logic [1:0] tcnt;

  localparam int S_IDLE = 0, S_UP = 1, S_DOWN = 2, S_HOLD = 3, S_FAULT = 4;

  pwm_ramp_controller #(.STEP_DIV(4), .STEP_SIZE(16), .WDT_STEPS(8)) dut (
    .i_Clock50MHz (clk),
    .i_Reset      (rst),
    .i_TargetValid(tvalid),
    .i_TargetDuty (tduty),
    .o_TargetReady(tready),
    .i_Enable     (enable),
    .i_ClearFault (clear_fault),
    .o_DutyCycle  (duty),
    .o_AtTarget   (at_target),
    .o_Busy       (busy),
    .o_Fault      (fault),
    .o_State      (state)
  );

  always #5 clk = ~clk;

  // Predicted step-tick phase: tick edge follows a cycle where tcnt==3
  always @(posedge clk or posedge rst) begin
    if (rst) tcnt <= 2'd0;
    else     tcnt <= tcnt + 2'd1;
  end

  initial begin
    #400000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int push_ramp(input int from, input int to);
    int d = from;
    int cnt = 0;
    while (d != to) begin
      if (to > d) d = (d + 16 > to) ? to : d + 16;
      else        d = (d - 16 < to) ? to : d - 16;
      exp_q.push_back(d);
      cnt++;
    end
    return cnt;
  endfunction

  task automatic wait_pre_tick();
    int k = 0;
    @(negedge clk);
    while (tcnt != 2'd3 && k < 16) begin
      @(negedge clk);
      k++;
    end
    if (k >= 16) chk("tick_timeout", 32'(k), 32'd0);
  endtask

  task automatic next_tick();
    wait_pre_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_duty(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(duty), 32'(e));
    end
  endtask

  task automatic run_ticks(input string tag, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      next_tick();
      chk_duty(tag);
    end
  endtask

  task automatic send(input logic [7:0] v);
    @(negedge clk);
    tvalid = 1'b1;
    tduty  = v;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_state", 32'(state), S_IDLE);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_at_target", 32'(at_target), 32'd1);
    chk("rst_ready", 32'(tready), 32'd1);
    chk("rst_fault", 32'(fault), 32'd0);

    // Soft start 0 -> 64
    send(8'd64);
    n = push_ramp(0, 64);
    run_ticks("up64", 1);
    chk("up64_state", 32'(state), S_UP);
    chk("up64_busy", 32'(busy), 32'd1);
    run_ticks("up64", n - 1);
    chk("up64_at_target", 32'(at_target), 32'd1);
    settle();
    chk("hold64_state", 32'(state), S_HOLD);
    chk("hold64_busy", 32'(busy), 32'd0);

    // Clamp at the top: 240 -> 250 must not wrap
    send(8'd240);
    n = push_ramp(64, 240);
    run_ticks("up240", n);
    send(8'd250);
    exp_q.push_back(250);
    run_ticks("clamp250", 1);
    settle();
    chk("hold250_state", 32'(state), S_HOLD);

    // Ramp down to 128, then soft stop to 0
    send(8'd128);
    n = push_ramp(250, 128);
    run_ticks("dn128", n);
    send(8'd0);
    n = push_ramp(128, 0);
    run_ticks("dn0", 1);
    chk("dn0_state", 32'(state), S_DOWN);
    run_ticks("dn0", n - 1);
    settle();
    chk("idle_state", 32'(state), S_IDLE);
    next_tick();
    chk("no_underflow", 32'(duty), 32'd0);

    // Reverse mid-ramp: at 48 heading to 100, command 20
    send(8'd100);
    n = push_ramp(0, 48);
    run_ticks("up48", n);
    send(8'd20);
    n = push_ramp(48, 20);
    run_ticks("rev20", 1);
    chk("rev20_state", 32'(state), S_DOWN);
    run_ticks("rev20", n - 1);
    settle();
    chk("hold20_state", 32'(state), S_HOLD);

    // Disable ramps to 0 and re-enable returns to stored target
    send(8'd100);
    n = push_ramp(20, 100);
    run_ticks("up100", n);
    @(negedge clk);
    enable = 1'b0;
    #1;
    chk("dis_at_target", 32'(at_target), 32'd0);
    n = push_ramp(100, 0);
    run_ticks("dis_dn", n);
    settle();
    chk("dis_idle_state", 32'(state), S_IDLE);
    @(negedge clk);
    enable = 1'b1;
    n = push_ramp(0, 100);
    run_ticks("en_up", n);
    settle();
    chk("en_hold_state", 32'(state), S_HOLD);

    // Acceptance on a tick edge steps toward the old target (100 -> stays 100)
    wait_pre_tick();
    tvalid = 1'b1;
    tduty  = 8'd50;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    chk("coincident_duty", 32'(duty), 32'd100);
    n = push_ramp(100, 50);
    run_ticks("dn50", n);
    settle();
    chk("hold50_state", 32'(state), S_HOLD);

    // Reset mid-ramp
    send(8'd200);
    n = push_ramp(50, 200);
    run_ticks("up200", 2);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_duty", 32'(duty), 32'd0);
    chk("mid_rst_state", 32'(state), S_IDLE);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_at_target", 32'(at_target), 32'd1);
    @(negedge clk);
    rst = 1'b0;

`ifdef PWM_RAMP_WATCHDOG_EN
    send(8'd64);
    n = push_ramp(0, 64);
    run_ticks("wdt_up", n);
    repeat (4) next_tick();
    chk("wdt_pre_fault", 32'(fault), 32'd0);
    settle();
    chk("wdt_fault", 32'(fault), 32'd1);
    chk("wdt_duty", 32'(duty), 32'd0);
    chk("wdt_ready", 32'(tready), 32'd0);
    chk("wdt_state", 32'(state), S_FAULT);
    @(negedge clk);
    clear_fault = 1'b1;
    @(posedge clk);
    #1;
    clear_fault = 1'b0;
    chk("clr_state", 32'(state), S_IDLE);
    chk("clr_ready", 32'(tready), 32'd1);
    chk("clr_fault", 32'(fault), 32'd0);
`else
    repeat (8) next_tick();
    chk("nowdt_fault", 32'(fault), 32'd0);
    chk("nowdt_ready", 32'(tready), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
